// File: rtl/fetch_controller.sv
// Fetch-stage controller: PC / IR2 / PC2 mux selects, stall and branch bubbles.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush event counters.
module fetch_controller #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic       redirect,
    output logic [1:0] selectmux0,
    output logic [1:0] selectmux1,
    output logic       selectmux2,
    output logic       fetch_active,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] PC_Z4   = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_HOLD = 2'd2;
    localparam logic [1:0] PC_BR   = 2'd3;

    localparam logic [1:0] IR_INSN = 2'd0;
    localparam logic [1:0] IR_NOP  = 2'd1;
    localparam logic [1:0] IR_HOLD = 2'd2;

    localparam logic PC2_INC  = 1'b0;
    localparam logic PC2_HOLD = 1'b1;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel0, sel1;
    logic       sel2;
    logic       stall_act;
    logic       flush_act;

    // Next state, bubble counter and mux selects by action priority
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel0      = PC_Z4;
        sel1      = IR_NOP;
        sel2      = PC2_HOLD;
        stall_act = 1'b0;
        flush_act = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (redirect || branch_taken) begin
                    // redirect wins over branch; both start a bubble window
                    flush_act = 1'b1;
                    sel0      = redirect ? PC_Z4 : PC_BR;
                    sel1      = IR_NOP;
                    sel2      = PC2_HOLD;
                    cnt_d     = FLUSH_LD;
                    state_d   = (FLUSH_LD == 4'd0) ? S_RUN : S_FLUSH;
                end else if (stall) begin
                    stall_act = 1'b1;
                    if (state_q == S_FLUSH) begin
                        // bubble count frozen while the pipe is held
                        sel0 = PC_HOLD;
                        sel1 = IR_NOP;
                        sel2 = PC2_HOLD;
                    end else begin
                        sel0    = PC_HOLD;
                        sel1    = IR_HOLD;
                        sel2    = PC2_HOLD;
                        state_d = S_STALL;
                    end
                end else if (state_q == S_FLUSH) begin
                    sel0 = PC_HOLD;
                    sel1 = IR_NOP;
                    sel2 = PC2_HOLD;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    sel0    = PC_INC;
                    sel1    = IR_INSN;
                    sel2    = PC2_INC;
                    state_d = S_RUN;
                end
            end
        endcase
        if (rst) begin
            sel0      = PC_Z4;
            sel1      = IR_NOP;
            sel2      = PC2_HOLD;
            stall_act = 1'b0;
            flush_act = 1'b0;
        end
    end

    // State and bubble counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output drive; reset forces the idle view immediately
    always_comb begin
        selectmux0   = sel0;
        selectmux1   = sel1;
        selectmux2   = sel2;
        fetch_active = !rst && (state_q != S_IDLE);
        state_o      = rst ? 2'd0 : state_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating event counter next values
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_act && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (flush_act && flush_count_q != 16'hFFFF) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // Event counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller (FLUSH_CYCLES=2) with a per-cycle
// reference model plus literal spot checks of the select outputs.
module tb_fetch_controller;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_valid = 1'b0;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic       redirect = 1'b0;
    logic [1:0] selectmux0;
    logic [1:0] selectmux1;
    logic       selectmux2;
    logic       fetch_active;
    logic [1:0] state_o;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // model: mode 0 idle, 1 run, 2 stalled, 3 bubbling
    int m_mode = 0;
    int m_left = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    fetch_controller #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .stall(stall),
        .branch_taken(branch_taken),
        .redirect(redirect),
        .selectmux0(selectmux0),
        .selectmux1(selectmux1),
        .selectmux2(selectmux2),
        .fetch_active(fetch_active),
`ifdef FETCH_PERF_CNT_EN
        .stall_count(stall_count),
        .flush_count(flush_count),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    function automatic logic [4:0] sel_now();
        return {selectmux0, selectmux1, selectmux2};
    endfunction

    // expected {sel0,sel1,sel2} from the current model mode and inputs
    function automatic logic [4:0] exp_sel();
        if (rst || m_mode == 0) return 5'b00_01_1;
        if (redirect) return 5'b00_01_1;
        if (branch_taken) return 5'b11_01_1;
        if (m_mode == 3) return 5'b10_01_1;
        if (stall) return 5'b10_10_1;
        return 5'b01_00_0;
    endfunction

    // model advance at each edge
    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_mode = 0;
            m_left = 0;
            m_stalls = 0;
            m_flushes = 0;
        end else if (m_mode == 0) begin
            if (start_valid) m_mode = 1;
        end else if (redirect || branch_taken) begin
            m_left = FC;
            m_mode = (FC == 0) ? 1 : 3;
            if (m_flushes < 65535) m_flushes++;
        end else if (stall) begin
            if (m_mode != 3) m_mode = 2;
            if (m_stalls < 65535) m_stalls++;
        end else if (m_mode == 3) begin
            m_left--;
            if (m_left <= 0) begin
                m_left = 0;
                m_mode = 1;
            end
        end else begin
            m_mode = 1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("model_sel", 32'(sel_now()), 32'(exp_sel()));
            chk("model_state", 32'(state_o), rst ? 32'd0 : 32'(m_mode));
            chk("model_active", 32'(fetch_active),
                32'(!rst && m_mode != 0));
            if (selectmux1 == 2'd3) chk("sel1_never3", 32'd3, 32'd0);
`ifdef FETCH_PERF_CNT_EN
            chk("model_stall_cnt", 32'(stall_count), 32'(m_stalls));
            chk("model_flush_cnt", 32'(flush_count), 32'(m_flushes));
`endif
        end
    end

    task automatic cyc(input logic r, input logic sv, input logic st,
                       input logic br, input logic rd);
        @(posedge clk);
        #1;
        rst = r;
        start_valid = sv;
        stall = st;
        branch_taken = br;
        redirect = rd;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [4:0] s,
                       input logic [1:0] st);
        #1;
        chk({name, "_sel"}, 32'(sel_now()), 32'(s));
        chk({name, "_state"}, 32'(state_o), 32'(st));
    endtask

    initial begin
        // reset two cycles, start on the third
        cyc(1, 0, 0, 1, 1); lit("rst1", 5'b00_01_1, 2'd0);
        chk("rst1_active", 32'(fetch_active), 32'd0);
        cyc(1, 1, 1, 0, 0); lit("rst2", 5'b00_01_1, 2'd0);
        cyc(0, 1, 0, 0, 0); lit("start", 5'b00_01_1, 2'd0);
        cyc(0, 0, 0, 0, 0); lit("run", 5'b01_00_0, 2'd1);
        chk("run_active", 32'(fetch_active), 32'd1);

        // three stall cycles then release resumes at once
        cyc(0, 0, 1, 0, 0); lit("stall1", 5'b10_10_1, 2'd1);
        cyc(0, 0, 1, 0, 0); lit("stall2", 5'b10_10_1, 2'd2);
        cyc(0, 0, 1, 0, 0); lit("stall3", 5'b10_10_1, 2'd2);
        cyc(0, 0, 0, 0, 0); lit("unstall", 5'b01_00_0, 2'd2);
        cyc(0, 0, 0, 0, 0); lit("run2", 5'b01_00_0, 2'd1);

        // branch with two bubbles; stall alongside loses to branch
        cyc(0, 0, 1, 1, 0); lit("branch", 5'b11_01_1, 2'd1);
        cyc(0, 0, 0, 0, 0); lit("bub1", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("bub2", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("after_br", 5'b01_00_0, 2'd1);

        // branch+redirect, then stall stretches the bubble window
        cyc(0, 0, 0, 1, 1); lit("redir", 5'b00_01_1, 2'd1);
        cyc(0, 0, 1, 0, 0); lit("fst1", 5'b10_01_1, 2'd3);
        cyc(0, 0, 1, 0, 0); lit("fst2", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("fb1", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("fb2", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("after_rd", 5'b01_00_0, 2'd1);

        // redirect inside the window reloads it
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0); lit("rl_b1", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 1); lit("rl_rd", 5'b00_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("rl_b2", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("rl_b3", 5'b10_01_1, 2'd3);
        cyc(0, 0, 0, 0, 0); lit("rl_run", 5'b01_00_0, 2'd1);

        // reset mid-window; only start_valid leaves idle
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0); lit("mid_rst", 5'b00_01_1, 2'd0);
        cyc(0, 0, 1, 1, 1); lit("idle_ign", 5'b00_01_1, 2'd0);
        cyc(0, 0, 0, 0, 0); lit("idle_hold", 5'b00_01_1, 2'd0);
        cyc(0, 1, 0, 0, 0); lit("restart", 5'b00_01_1, 2'd0);
        cyc(0, 0, 0, 0, 0); lit("rerun", 5'b01_00_0, 2'd1);

        // reset while stalled
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0); lit("pre_rst", 5'b10_10_1, 2'd2);
        cyc(1, 0, 1, 0, 0); lit("stall_rst", 5'b00_01_1, 2'd0);
        cyc(0, 0, 0, 0, 0); lit("post_rst", 5'b00_01_1, 2'd0);

`ifdef FETCH_PERF_CNT_EN
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 70000; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("stall_sat", 32'(stall_count), 32'h0000FFFF);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        chk("flush3", 32'(flush_count), 32'd3);
        chk("stall0", 32'(stall_count), 32'd0);
`endif

        cyc(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 1, meaning extra PC-hold/NOP bubble cycles after a taken branch or redirect (legal range 0..15).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start_valid  input  1  z4 start vector valid; leave IDLE.
REQ-005 The block SHALL have port stall  input  1  downstream hazard; hold the fetch stage.
REQ-006 The block SHALL have port branch_taken  input  1  load the branch address into the PC.
REQ-007 The block SHALL have port redirect  input  1  load z4 into the PC (exception/restart).
REQ-008 The block SHALL have port selectmux0  output  2  PC source: 0=z4, 1=pc+4, 2=hold, 3=branch address.
REQ-009 The block SHALL have port selectmux1  output  2  IR2 source: 0=instruction, 1=nop, 2=hold.
REQ-010 The block SHALL have port selectmux2  output  1  PC2 source: 0=pc+4, 1=hold.
REQ-011 The block SHALL have ports fetch_active  output  1  (state!=IDLE) and state_o  output  2  (IDLE=0, RUN=1, STALL=2, FLUSH=3).

Function
REQ-012 The states SHALL be IDLE, RUN, STALL and FLUSH, with a 4-bit bubble counter.
REQ-013 All select outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-014 In IDLE, the block SHALL drive selects (0,1,1), ignore stall, branch_taken and redirect, and go to RUN on start_valid.
REQ-015 Outside IDLE, each cycle's action SHALL be chosen by priority: redirect > branch_taken > stall > normal.
REQ-016 On redirect, the block SHALL drive (0,1,1) and load the counter with FLUSH_CYCLES; the next state SHALL be FLUSH, or RUN if FLUSH_CYCLES=0.
REQ-017 On branch_taken, the block SHALL drive (3,1,1); counter load and next state SHALL be as in REQ-016.
REQ-018 On stall in RUN or STALL, the block SHALL drive (2,2,1) and go to STALL.
REQ-019 On normal action in RUN or STALL, the block SHALL drive (1,0,0) and go to RUN, so stall release resumes fetch in the same cycle.
REQ-020 In FLUSH, the block SHALL drive (2,1,1); on normal action it SHALL decrement the counter and go to RUN when the counter reaches 0; while stall is high the counter SHALL hold.
REQ-021 Branch_taken or redirect in FLUSH SHALL reload the counter and stay in FLUSH, with outputs per REQ-016/017.
REQ-022 Simultaneous branch_taken and redirect SHALL resolve to redirect; simultaneous branch_taken and stall SHALL resolve to branch.
REQ-023 The block SHALL never emit selectmux1=3 or select combinations outside those listed above.

Reset
REQ-024 While rst=1, outputs SHALL be (0,1,1), fetch_active=0 and state_o=0, overriding all other inputs.
REQ-025 At the clock edge with rst=1, the block SHALL set state=IDLE, counter=0 and, if present, performance counters=0, including mid-FLUSH or mid-STALL.
REQ-026 After rst deasserts, the block SHALL remain in IDLE until start_valid=1.

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs stall_count[15:0] and flush_count[15:0].
REQ-028 With FETCH_PERF_CNT_EN, stall_count SHALL increment every stall action outside IDLE, and flush_count SHALL increment on every accepted branch or redirect; both SHALL saturate at 16'hFFFF.
REQ-029 Without FETCH_PERF_CNT_EN, these ports and registers SHALL be absent, with identical select behaviour.

Verification
REQ-030 The bench SHALL cover: rst 2 cycles, then start_valid at cycle 3 -> selects (0,1,1) through cycle 3, (1,0,0) from cycle 4, state_o=1.
REQ-031 The bench SHALL cover: RUN, stall high 3 cycles -> (2,2,1) for exactly 3 cycles, state_o=2; stall low -> (1,0,0) in the same cycle.
REQ-032 The bench SHALL cover: FLUSH_CYCLES=2, branch_taken 1 cycle -> (3,1,1), then (2,1,1) for 2 cycles, then (1,0,0).
REQ-033 The bench SHALL cover: FLUSH_CYCLES=2, branch_taken and redirect together, then stall during FLUSH -> (0,1,1), then FLUSH extended by the stall cycles.
REQ-034 The bench SHALL cover: rst asserted mid-FLUSH -> state_o=0 next cycle; start_valid is required to resume.
REQ-035 The bench SHALL cover: with FETCH_PERF_CNT_EN, 70000 stall cycles -> stall_count=16'hFFFF; 3 branches -> flush_count=3.
